// File: rtl/cordic_vectoring_iterative.sv
// ---------------------------------------------------------------------------
// cordic_vectoring_iterative
//
// Iterative CORDIC in vectoring mode. Converts a Cartesian vector (x, y) into
// a gain-scaled magnitude and an angle. One shared add/shift datapath performs
// one micro-rotation per clock over ITERATIONS cycles.
//
// Angle format: 2^N_FRAC LSB = pi (128 LSB = pi for N_FRAC = 7). This is the
// same format the rotation-mode block consumes, so angle_o can be fed to it.
//
// Ports
//   clk_i                    in   clock, rising edge
//   rst_i                    in   asynchronous reset, active low
//   x_i, y_i                 in   signed Q0.N_FRAC vector components
//   data_in_valid_strobe_i   in   one-cycle input qualifier (sampled in IDLE)
//   mag_o                    out  |v| * K (K ~= 1.6464 for 6 iterations), >= 0
//   angle_o                  out  atan2(y, x), saturated to the N_FRAC+1 range
//   data_out_valid_strobe_o  out  one-cycle result qualifier
//   busy_o                   out  high whenever the block is not idle
//
// Timing: strobe sampled at edge k, micro-rotations at edges k+1..k+6,
// results and valid at edge k+6, back to idle at edge k+7. Strobes seen while
// busy are dropped.
// ---------------------------------------------------------------------------
module cordic_vectoring_iterative #(
    parameter int N_FRAC     = 7,
    parameter int ITERATIONS = 6,
    parameter int GUARD      = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic signed [N_FRAC:0]      x_i,
    input  logic signed [N_FRAC:0]      y_i,
    input  logic                        data_in_valid_strobe_i,
    output logic signed [N_FRAC+GUARD:0] mag_o,
    output logic signed [N_FRAC:0]      angle_o,
    output logic                        data_out_valid_strobe_o,
    output logic                        busy_o
);

    // Widths: external sample, internal x/y (with guard MSBs), internal angle.
    localparam int W  = N_FRAC + 1;
    localparam int XW = W + GUARD;
    localparam int ZW = N_FRAC + 3;
    localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    // atan(2^-i) truncated, expressed with pi = 2^15. Entries for the active
    // angle resolution are obtained by a right shift, which preserves
    // truncation (floor of floor). Valid for N_FRAC <= 15 and ITERATIONS <= 16.
    localparam int ATAN_REF [16] = '{
        8192, 4836, 2555, 1297, 651, 325, 162, 81,
        40,   20,   10,   5,    2,   1,   0,   0
    };

    // Pre-rotation angle of a quarter turn (pi/2).
    localparam logic signed [ZW-1:0] Z_QUARTER = ZW'(1 << (N_FRAC - 1));

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [CW-1:0]          cnt_reg;
    logic signed [XW-1:0]   x_reg;
    logic signed [XW-1:0]   y_reg;
    logic signed [ZW-1:0]   z_reg;

    // Constant angle table, one entry per iteration.
    logic signed [ZW-1:0]   atan_tab [ITERATIONS];

    genvar gi;
    generate
        for (gi = 0; gi < ITERATIONS; gi++) begin : g_atan
            assign atan_tab[gi] = ZW'(ATAN_REF[gi] >>> (15 - N_FRAC));
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Pre-rotation into the right half-plane. Negation happens at internal
    // width, so -(-2^N_FRAC) is representable and does not wrap.
    // ---------------------------------------------------------------------
    logic signed [XW-1:0]   x_ext;
    logic signed [XW-1:0]   y_ext;
    logic signed [XW-1:0]   x_pre;
    logic signed [XW-1:0]   y_pre;
    logic signed [ZW-1:0]   z_pre;

    assign x_ext = {{GUARD{x_i[W-1]}}, x_i};
    assign y_ext = {{GUARD{y_i[W-1]}}, y_i};

    always_comb begin
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = '0;
        if (x_i[W-1]) begin
            if (!y_i[W-1]) begin
                // Second quadrant: rotate by -pi/2.
                x_pre = y_ext;
                y_pre = -x_ext;
                z_pre = Z_QUARTER;
            end else begin
                // Third quadrant: rotate by +pi/2.
                x_pre = -y_ext;
                y_pre = x_ext;
                z_pre = -Z_QUARTER;
            end
        end
    end

    // ---------------------------------------------------------------------
    // One micro-rotation. Both updates use the pre-iteration x and y; the
    // direction drives y towards zero.
    // ---------------------------------------------------------------------
    logic signed [XW-1:0]   x_sh;
    logic signed [XW-1:0]   y_sh;
    logic signed [ZW-1:0]   atan_cur;
    logic signed [XW-1:0]   x_next;
    logic signed [XW-1:0]   y_next;
    logic signed [ZW-1:0]   z_next;
    logic signed [W-1:0]    z_sat;
    logic                   last_iter;

    assign x_sh      = x_reg >>> cnt_reg;
    assign y_sh      = y_reg >>> cnt_reg;
    assign atan_cur  = atan_tab[cnt_reg];
    assign last_iter = (cnt_reg == CW'(ITERATIONS - 1));

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        z_next = z_reg;
        if (!y_reg[XW-1]) begin
            x_next = x_reg + y_sh;
            y_next = y_reg - x_sh;
            z_next = z_reg + atan_cur;
        end else begin
            x_next = x_reg - y_sh;
            y_next = y_reg + x_sh;
            z_next = z_reg - atan_cur;
        end
    end

    // Saturate the angle: it is in range when all bits above the output sign
    // bit agree with it; otherwise clamp to the most positive/negative code.
    always_comb begin
        z_sat = z_next[W-1:0];
        if (z_next[ZW-1:W-1] != {(ZW - W + 1){z_next[ZW-1]}}) begin
            z_sat = z_next[ZW-1] ? {1'b1, {(W - 1){1'b0}}}
                                 : {1'b0, {(W - 1){1'b1}}};
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg               <= ST_IDLE;
            cnt_reg                 <= '0;
            x_reg                   <= '0;
            y_reg                   <= '0;
            z_reg                   <= '0;
            mag_o                   <= '0;
            angle_o                 <= '0;
            data_out_valid_strobe_o <= 1'b0;
            busy_o                  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    data_out_valid_strobe_o <= 1'b0;
                    if (data_in_valid_strobe_i) begin
                        x_reg     <= x_pre;
                        y_reg     <= y_pre;
                        z_reg     <= z_pre;
                        cnt_reg   <= '0;
                        busy_o    <= 1'b1;
                        state_reg <= ST_CALC;
                    end
                end

                ST_CALC: begin
                    x_reg <= x_next;
                    y_reg <= y_next;
                    z_reg <= z_next;
                    if (last_iter) begin
                        mag_o                   <= x_next;
                        angle_o                 <= z_sat;
                        data_out_valid_strobe_o <= 1'b1;
                        state_reg               <= ST_OUTPUT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_OUTPUT: begin
                    data_out_valid_strobe_o <= 1'b0;
                    busy_o                  <= 1'b0;
                    state_reg               <= ST_IDLE;
                end

                default: begin
                    data_out_valid_strobe_o <= 1'b0;
                    busy_o                  <= 1'b0;
                    state_reg               <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring_iterative.sv
// ---------------------------------------------------------------------------
// tb_cordic_vectoring_iterative
//
// Self-checking bench for cordic_vectoring_iterative. Each result is compared
// exactly against an integer CORDIC model and loosely against ideal atan2 and
// magnitude values. Covers reset, latency/handshake, quadrant boundaries,
// ignored strobes while busy, mid-computation reset, a circle sweep and
// random vectors.
// ---------------------------------------------------------------------------
module tb_cordic_vectoring_iterative;

    localparam int    N_FRAC = 7;
    localparam int    ITER   = 6;
    localparam int    GUARD  = 2;
    localparam real   PI     = 3.14159265358979;
    localparam real   K_GAIN = 1.6464;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic signed [N_FRAC:0]       x_in = '0;
    logic signed [N_FRAC:0]       y_in = '0;
    logic                         strobe = 1'b0;
    logic signed [N_FRAC+GUARD:0] mag;
    logic signed [N_FRAC:0]       ang;
    logic                         valid;
    logic                         busy;

    int total = 0;
    int bad   = 0;
    int atan_tab [ITER] = '{32, 18, 9, 5, 2, 1};

    cordic_vectoring_iterative #(
        .N_FRAC     (N_FRAC),
        .ITERATIONS (ITER),
        .GUARD      (GUARD)
    ) dut (
        .clk_i                   (clk),
        .rst_i                   (rst_n),
        .x_i                     (x_in),
        .y_i                     (y_in),
        .data_in_valid_strobe_i  (strobe),
        .mag_o                   (mag),
        .angle_o                 (ang),
        .data_out_valid_strobe_o (valid),
        .busy_o                  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Integer CORDIC following the vectoring rules: quadrant pre-rotation,
    // then ITER micro-rotations driving y towards zero, angle saturated.
    function automatic void model(input int x, input int y, output int m, output int a);
        int xx, yy, zz, xs, ys;
        if (x >= 0) begin
            xx = x;  yy = y;  zz = 0;
        end else if (y >= 0) begin
            xx = y;  yy = -x; zz = 64;
        end else begin
            xx = -y; yy = x;  zz = -64;
        end
        for (int i = 0; i < ITER; i++) begin
            xs = xx >>> i;
            ys = yy >>> i;
            if (yy >= 0) begin
                xx = xx + ys; yy = yy - xs; zz = zz + atan_tab[i];
            end else begin
                xx = xx - ys; yy = yy + xs; zz = zz - atan_tab[i];
            end
        end
        m = xx;
        a = (zz > 127) ? 127 : ((zz < -128) ? -128 : zz);
    endfunction

    function automatic int ideal_ang(input int x, input int y);
        real r;
        int  v;
        r = $atan2(real'(y), real'(x)) * 128.0 / PI;
        v = int'(r);
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Send one vector, wait for its result and check timing and values.
    task automatic run_vec(input int x, input int y, input string tag);
        int  m_exp, a_exp, lat, busy_cnt, m_obs, a_obs, m_ideal;
        bit  seen;
        model(x, y, m_exp, a_exp);
        @(negedge clk);
        x_in   = 8'(x);
        y_in   = 8'(y);
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        // Inputs change during the computation; they must be ignored.
        x_in   = 8'($urandom);
        y_in   = 8'($urandom);
        check({tag, "_busy_start"}, int'(busy), 1);
        busy_cnt = int'(busy);
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (valid) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        check({tag, "_latency"}, lat, ITER);
        check({tag, "_busy_cycles"}, busy_cnt, 7);
        m_obs = int'(mag);
        a_obs = int'(ang);
        check({tag, "_mag"}, m_obs, m_exp);
        check({tag, "_ang"}, a_obs, a_exp);
        m_ideal = int'($sqrt(real'(x * x + y * y)) * K_GAIN);
        check({tag, "_ang_near_ideal"}, int'(iabs(a_obs - ideal_ang(x, y)) <= 3), 1);
        check({tag, "_mag_near_ideal"}, int'(iabs(m_obs - m_ideal) <= 4), 1);
        @(negedge clk);
        check({tag, "_valid_one_cycle"}, int'(valid), 0);
        check({tag, "_busy_end"}, int'(busy), 0);
        check({tag, "_mag_hold"}, int'(mag), m_obs);
        $display("vec %s x=%0d y=%0d mag=%0d ang=%0d (model mag=%0d ang=%0d) lat=%0d",
                 tag, x, y, m_obs, a_obs, m_exp, a_exp, lat);
    endtask

    initial begin
        int m_a, a_a, m_d, a_d, vcnt;
        bit v7, v15;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mag", int'(mag), 0);
        check("rst_ang", int'(ang), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors and quadrant boundaries
        run_vec(64, 0, "x_axis");
        run_vec(0, 64, "y_axis");
        run_vec(-64, 0, "neg_x_axis");
        run_vec(-128, -128, "corner_min");
        run_vec(64, -64, "q4_diag");
        run_vec(127, 127, "corner_max");
        run_vec(-128, 127, "q2_extreme");

        // Strobes at k (A), k+3 (B), k+7 (C) and k+8 (D): only A and D run.
        model(100, 30, m_a, a_a);
        model(20, -110, m_d, a_d);
        vcnt = 0; v7 = 1'b0; v15 = 1'b0;
        @(negedge clk);
        x_in = 8'(100); y_in = 8'(30); strobe = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            if (valid) vcnt++;
            if (n == 7) begin
                v7 = valid;
                check("multi_a_mag", int'(mag), m_a);
                check("multi_a_ang", int'(ang), a_a);
            end
            if (n == 15) begin
                v15 = valid;
                check("multi_d_mag", int'(mag), m_d);
                check("multi_d_ang", int'(ang), a_d);
            end
            strobe = 1'b0;
            case (n)
                3: begin x_in = 8'(-50); y_in = 8'(70);   strobe = 1'b1; end
                7: begin x_in = 8'(-90); y_in = 8'(-20);  strobe = 1'b1; end
                8: begin x_in = 8'(20);  y_in = 8'(-110); strobe = 1'b1; end
                default: ;
            endcase
        end
        check("multi_valid_at_k6", int'(v7), 1);
        check("multi_valid_at_k14", int'(v15), 1);
        check("multi_valid_count", vcnt, 2);
        $display("vec multi A/D pulses=%0d", vcnt);

        // Reset during CALC aborts with no output strobe
        @(negedge clk);
        x_in = 8'(100); y_in = 8'(50); strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_mag", int'(mag), 0);
        check("midrst_ang", int'(ang), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_busy", int'(busy), 0);
        vcnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (valid) vcnt++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (valid || busy) vcnt++;
        end
        check("midrst_no_activity", vcnt, 0);
        $display("vec midrst activity=%0d", vcnt);
        run_vec(-70, 90, "after_rst");

        // Circle sweep, radius 100
        for (int k = 0; k < 16; k++) begin
            real th;
            th = real'(k) * 2.0 * PI / 16.0;
            run_vec(int'(100.0 * $cos(th)), int'(100.0 * $sin(th)), $sformatf("sweep%0d", k));
        end

        // Random vectors
        for (int r = 0; r < 20; r++) begin
            run_vec(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                    $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
